// File: rtl/thr_wait_sched.sv
// Four-thread wait-aware round-robin scheduler; a thread keeps the pipe for QUANTUM advances while others wait.
// Latency: registered outputs, one cycle per FSM hop. Optional starvation monitor under `ifdef THR_SCHED_STARVE_EN.
module thr_wait_sched #(
  parameter int QUANTUM      = 8,
  parameter int STARVE_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [3:0] thr_en,
  input  logic [3:0] wm_imiss,
  input  logic [3:0] wm_other,
  input  logic [3:0] wm_stbwait,
  input  logic [3:0] mul_wait,
  input  logic [3:0] div_wait,
  input  logic [3:0] fp_wait,
  input  logic [3:0] ldmiss,
  input  logic       adv,
  output logic [3:0] thr_sel,
  output logic       thr_sel_vld,
  output logic       sw_pulse,
  output logic [3:0] starve_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  localparam logic [7:0] Q_LAST = 8'(QUANTUM - 1);

  if (QUANTUM < 2 || QUANTUM > 255 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_param_chk
    $error("thr_wait_sched: QUANTUM or STARVE_LIMIT out of range");
  end

  logic [3:0] ready;
  logic [3:0] cur_oh;
  logic [3:0] others_rdy;
  logic [1:0] state_q, state_d;
  logic [1:0] cur_q, cur_d;
  logic [7:0] qcnt_q, qcnt_d;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       pick_vld;

  assign ready      = thr_en & ~(wm_imiss | wm_other | wm_stbwait | mul_wait |
                                 div_wait | fp_wait | ldmiss);
  assign cur_oh     = 4'b0001 << cur_q;
  assign others_rdy = ready & ~cur_oh;

  // cur_q doubles as "last granted": search last+1 .. last+4, so cur itself is the final candidate
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = cur_q;
    cand     = cur_q;
    for (int k = 1; k <= 4; k++) begin
      cand = cur_q + 2'(k);
      if (!pick_vld && ready[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_RUN;
          cur_d   = pick_idx;
          qcnt_d  = '0;
        end
      end
      ST_RUN: begin
        // a stalled or disabled owner yields regardless of adv or quantum state
        if (!ready[cur_q]) begin
          state_d = ST_SWITCH;
        end else if (adv) begin
          if (qcnt_q == Q_LAST) begin
            if (|others_rdy) state_d = ST_SWITCH;
            else             qcnt_d  = '0;
          end else begin
            qcnt_d = qcnt_q + 8'd1;
          end
        end
      end
      ST_SWITCH: begin
        if (pick_vld) begin
          state_d = ST_RUN;
          cur_d   = pick_idx;
          qcnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      cur_q       <= 2'd3;
      qcnt_q      <= '0;
      thr_sel     <= 4'b0000;
      thr_sel_vld <= 1'b0;
      sw_pulse    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      qcnt_q      <= qcnt_d;
      // outputs are decoded from the next state so they line up with state_q
      thr_sel     <= (state_d == ST_RUN) ? (4'b0001 << cur_d) : 4'b0000;
      thr_sel_vld <= (state_d == ST_RUN);
      sw_pulse    <= (state_d == ST_SWITCH);
    end
  end

`ifdef THR_SCHED_STARVE_EN
  localparam logic [7:0] S_LIM = 8'(STARVE_LIMIT);

  logic [7:0] scnt_q [4];
  logic [3:0] granted;

  assign granted = (state_q == ST_RUN) ? cur_oh : 4'b0000;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < 4; i++) scnt_q[i] <= '0;
      starve_err <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!ready[i] || granted[i])  scnt_q[i] <= '0;
        else if (scnt_q[i] != S_LIM)  scnt_q[i] <= scnt_q[i] + 8'd1;
        if (scnt_q[i] == S_LIM)       starve_err[i] <= 1'b1;
      end
    end
  end
`else
  assign starve_err = 4'b0000;
`endif

endmodule
